tpu_csr: RTL

TPU_CSR -- requirements
Module: tpu_csr

---
 rtl/tpu_csr.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/tpu_csr.sv
// TPU control/status register block: config registers, start/busy/done tracking, completion irq.
// Optional TPU_CSR_PERF_CNT_EN turns register 8 into a saturating busy-cycle counter.
module tpu_csr #(
  parameter int NUM_REGS = 16,
  parameter int MADDR_W  = 16,
  parameter int RA_W     = $clog2(NUM_REGS)
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               we_i,
  input  logic               re_i,
  input  logic [RA_W-1:0]    addr_i,
  input  logic [31:0]        wdata_i,
  output logic [31:0]        rdata_o,
  output logic               rvalid_o,
  output logic               start_o,
  input  logic               valid_i,
  output logic [MADDR_W-1:0] m_o,
  output logic [MADDR_W-1:0] k_o,
  output logic [MADDR_W-1:0] n_o,
  output logic [MADDR_W-1:0] base_addra_o,
  output logic [MADDR_W-1:0] base_addrb_o,
  output logic [MADDR_W-1:0] base_addrp_o,
  output logic               irq_o
);

  // state  | meaning
  // S_IDLE | no job outstanding, START accepted, config writable
  // S_BUSY | job running, waiting for a valid_i rise
  typedef enum logic {S_IDLE, S_BUSY} state_e;

  state_e state_q, state_d;

  logic               valid_q, start_q, irq_en_q, done_q, err_q, irq_q, rvalid_q;
  logic [31:0]        rdata_q, rd_mux;
  logic [MADDR_W-1:0] cfg_q [8];
  logic [31:0]        scratch_q [NUM_REGS];

  logic busy, done_evt, wr_ctrl, wr_status, wr_cfg, wr_scratch;
  logic start_req, start_acc, err_set;

  assign busy      = (state_q == S_BUSY);
  assign done_evt  = valid_i & ~valid_q & busy;
  assign wr_ctrl   = we_i && (addr_i == RA_W'(0));
  assign wr_status = we_i && (addr_i == RA_W'(1));
  assign wr_cfg    = we_i && (addr_i >= RA_W'(2)) && (addr_i <= RA_W'(7));
`ifdef TPU_CSR_PERF_CNT_EN
  assign wr_scratch = we_i && (addr_i > RA_W'(8));
`else
  assign wr_scratch = we_i && (addr_i >= RA_W'(8));
`endif
  assign start_req = wr_ctrl & wdata_i[0];
  // A done event in the same cycle frees the core, so the new START is taken.
  assign start_acc = start_req & (~busy | done_evt);
  assign err_set   = busy & ((start_req & ~done_evt) | wr_cfg);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_acc) state_d = S_BUSY;
      S_BUSY:  if (start_acc) state_d = S_BUSY;
               else if (done_evt) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= 1'b0;
      start_q  <= 1'b0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
      for (int i = 0; i < 8; i++) cfg_q[i] <= '0;
    end else begin
      valid_q <= valid_i;
      start_q <= start_acc;
      irq_q   <= irq_en_q & done_q;
      if (wr_ctrl) irq_en_q <= wdata_i[1];
      // Set has priority over the W1C clear for both sticky flags.
      if (done_evt)                       done_q <= 1'b1;
      else if (wr_status && wdata_i[1])   done_q <= 1'b0;
      if (err_set)                        err_q  <= 1'b1;
      else if (wr_status && wdata_i[2])   err_q  <= 1'b0;
      if (wr_cfg && !busy) cfg_q[addr_i[2:0]] <= wdata_i[MADDR_W-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REGS; i++) scratch_q[i] <= '0;
    end else if (wr_scratch) begin
      scratch_q[addr_i] <= wdata_i;
    end
  end

`ifdef TPU_CSR_PERF_CNT_EN
  logic [31:0] cycles_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                       cycles_q <= '0;
    else if (start_q)                  cycles_q <= '0;
    else if (busy && (cycles_q != '1)) cycles_q <= cycles_q + 32'd1;
  end
`endif

  always_comb begin
    rd_mux = '0;
    if (addr_i == RA_W'(0))
      rd_mux = {30'b0, irq_en_q, 1'b0};
    else if (addr_i == RA_W'(1))
      rd_mux = {29'b0, err_q, done_q, busy};
    else if (addr_i <= RA_W'(7))
      rd_mux = 32'(cfg_q[addr_i[2:0]]);
`ifdef TPU_CSR_PERF_CNT_EN
    else if (addr_i == RA_W'(8))
      rd_mux = cycles_q;
`endif
    else
      rd_mux = scratch_q[addr_i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= re_i;
      if (re_i) rdata_q <= rd_mux;
    end
  end

  assign rdata_o      = rdata_q;
  assign rvalid_o     = rvalid_q;
  assign start_o      = start_q;
  assign irq_o        = irq_q;
  assign m_o          = cfg_q[2];
  assign k_o          = cfg_q[3];
  assign n_o          = cfg_q[4];
  assign base_addra_o = cfg_q[5];
  assign base_addrb_o = cfg_q[6];
  assign base_addrp_o = cfg_q[7];

endmodule
